// File: rtl/seq_mag_compare_pkg.sv
// Shared types and result encoding for the bit-serial magnitude comparator.
package seq_mag_compare_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Result flags packed as {gt, eq, lt}
    typedef logic [2:0] res_t;

    localparam res_t RES_GT   = 3'b100;
    localparam res_t RES_EQ   = 3'b010;
    localparam res_t RES_LT   = 3'b001;
    localparam res_t RES_NONE = 3'b000;

    function automatic res_t diff_res(input logic a_greater);
        diff_res = a_greater ? RES_GT : RES_LT;
    endfunction

endpackage

// File: rtl/seq_mag_compare_cmp_bit.sv
// Single-bit compare cell; inv swaps the sense of the bit so a 0 wins (two's complement sign bit).
module cmp_bit (
    input  logic ai,
    input  logic bi,
    input  logic inv,
    output logic g,
    output logic e
);

    assign e = ~(ai ^ bi);
    assign g = (ai ^ inv) & ~(bi ^ inv);

endmodule

// File: rtl/seq_mag_compare.sv
// Bit-serial MSB-first magnitude comparator with optional early exit.
// Define SEQ_MAG_COMPARE_SIGNED_EN to add the signed_mode port and signed MSB handling.
module seq_mag_compare
    import seq_mag_compare_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SEQ_MAG_COMPARE_SIGNED_EN
    input  logic             signed_mode,
`endif
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int               IDX_W   = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LSB = {IDX_W{1'b0}};
    localparam bit               EE      = (EARLY_EXIT != 0);

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [IDX_W-1:0] idx_r;
    logic             found_r;
    res_t             lat_r;
    res_t             res_r;
    res_t             res_s;
    logic             busy_r;
    logic             done_r;
    logic             accept_s;
    logic             inv_s;
    logic             g_s;
    logic             e_s;

    assign accept_s = start && ((state_r == IDLE) || (state_r == DONE));

`ifdef SEQ_MAG_COMPARE_SIGNED_EN
    logic sgn_r;

    // Mode captured with the operands so later changes on signed_mode cannot disturb a scan
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sgn_r <= 1'b0;
        end else if (accept_s) begin
            sgn_r <= signed_mode;
        end
    end

    assign inv_s = sgn_r && (idx_r == IDX_MSB);
`else
    assign inv_s = 1'b0;
`endif

    cmp_bit u_cmp_bit (
        .ai  (a_sh_r[WIDTH-1]),
        .bi  (b_sh_r[WIDTH-1]),
        .inv (inv_s),
        .g   (g_s),
        .e   (e_s)
    );

    // Next-state and next-result decode
    always_comb begin
        state_s = state_r;
        res_s   = res_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = SCAN;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (EE && !e_s) begin
                    state_s = DONE;
                    res_s   = diff_res(g_s);
                end else if (idx_r == IDX_LSB) begin
                    state_s = DONE;
                    // An earlier difference outranks anything seen in lower bits
                    if (found_r) begin
                        res_s = lat_r;
                    end else if (!e_s) begin
                        res_s = diff_res(g_s);
                    end else begin
                        res_s = RES_EQ;
                    end
                end else begin
                    state_s = SCAN;
                end
            end
            DONE: begin
                if (start) begin
                    state_s = SCAN;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Control state, status and result flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            res_r   <= RES_NONE;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == SCAN);
            done_r  <= (state_s == DONE);
            res_r   <= res_s;
        end
    end

    // Operand shift registers, bit index and first-difference latch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh_r  <= {WIDTH{1'b0}};
            b_sh_r  <= {WIDTH{1'b0}};
            idx_r   <= IDX_LSB;
            found_r <= 1'b0;
            lat_r   <= RES_NONE;
        end else if (accept_s) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            idx_r   <= IDX_MSB;
            found_r <= 1'b0;
            lat_r   <= RES_NONE;
        end else if (state_r == SCAN) begin
            a_sh_r <= {a_sh_r[WIDTH-2:0], 1'b0};
            b_sh_r <= {b_sh_r[WIDTH-2:0], 1'b0};
            idx_r  <= idx_r - IDX_ONE;
            if (!e_s && !found_r) begin
                found_r <= 1'b1;
                lat_r   <= diff_res(g_s);
            end
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign {gt, eq, lt}  = res_r;

endmodule

// File: tb/tb_seq_mag_compare.sv
// Directed bench: two WIDTH=8 instances (early exit on/off) share stimulus; a WIDTH=2 instance is swept.
module tb_seq_mag_compare;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       signed_mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       start2;
    logic [1:0] a2;
    logic [1:0] b2;

    logic busy_e, done_e, gt_e, eq_e, lt_e;
    logic busy_f, done_f, gt_f, eq_f, lt_f;
    logic busy_w, done_w, gt_w, eq_w, lt_w;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n;
    int lat_e, lat_f, nd_e, nd_f;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vs;
        int         le;
        int         lf;
        logic [2:0] fl;
    } vec_t;

    vec_t vt[$];

    always #5 clk = ~clk;

    seq_mag_compare #(.WIDTH(8), .EARLY_EXIT(1)) dut_e (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
`ifdef SEQ_MAG_COMPARE_SIGNED_EN
        .signed_mode(signed_mode),
`endif
        .busy(busy_e), .done(done_e), .gt(gt_e), .eq(eq_e), .lt(lt_e)
    );

    seq_mag_compare #(.WIDTH(8), .EARLY_EXIT(0)) dut_f (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
`ifdef SEQ_MAG_COMPARE_SIGNED_EN
        .signed_mode(signed_mode),
`endif
        .busy(busy_f), .done(done_f), .gt(gt_f), .eq(eq_f), .lt(lt_f)
    );

    seq_mag_compare #(.WIDTH(2), .EARLY_EXIT(1)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
`ifdef SEQ_MAG_COMPARE_SIGNED_EN
        .signed_mode(1'b0),
`endif
        .busy(busy_w), .done(done_w), .gt(gt_w), .eq(eq_w), .lt(lt_w)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cnt();
        edge_n = 0;
        lat_e  = -1;
        lat_f  = -1;
        nd_e   = 0;
        nd_f   = 0;
    endtask

    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            edge_n++;
            if (done_e === 1'b1) begin
                if (nd_e == 0) lat_e = edge_n;
                nd_e++;
            end
            if (done_f === 1'b1) begin
                if (nd_f == 0) lat_f = edge_n;
                nd_f++;
            end
        end
    endtask

    task automatic launch(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts);
        a           = ta;
        b           = tb_v;
        signed_mode = ts;
        start       = 1'b1;
        tick();
        start = 1'b0;
        clear_cnt();
    endtask

    task automatic check_run(input string tag, input int le, input int lf, input logic [2:0] fl);
        chk({tag, "_lat_e"}, lat_e, le);
        chk({tag, "_lat_f"}, lat_f, lf);
        chk({tag, "_ndone_e"}, nd_e, 1);
        chk({tag, "_ndone_f"}, nd_f, 1);
        chk({tag, "_flags_e"}, {gt_e, eq_e, lt_e}, fl);
        chk({tag, "_flags_f"}, {gt_f, eq_f, lt_f}, fl);
    endtask

    initial begin
        logic seen;

        rst_n       = 1'b0;
        start       = 1'b0;
        signed_mode = 1'b0;
        a           = 8'h00;
        b           = 8'h00;
        start2      = 1'b0;
        a2          = 2'b00;
        b2          = 2'b00;
        tick();
        tick();
        chk("rst_busy_e",  busy_e, 0);
        chk("rst_done_e",  done_e, 0);
        chk("rst_flags_e", {gt_e, eq_e, lt_e}, 3'b000);
        chk("rst_busy_f",  busy_f, 0);
        chk("rst_done_f",  done_f, 0);
        chk("rst_flags_f", {gt_f, eq_f, lt_f}, 3'b000);
        chk("rst_flags_w", {gt_w, eq_w, lt_w}, 3'b000);
        rst_n = 1'b1;
        tick();

        // Expected latency: edge of deciding bit (MSB decided at edge 1), 8 for full scan
        vt.push_back('{8'hA5, 8'hA5, 1'b0, 8, 8, 3'b010});
        vt.push_back('{8'h80, 8'h7F, 1'b0, 1, 8, 3'b100});
        vt.push_back('{8'h7F, 8'h80, 1'b0, 1, 8, 3'b001});
        vt.push_back('{8'h40, 8'h00, 1'b0, 2, 8, 3'b100});
        vt.push_back('{8'h12, 8'h13, 1'b0, 8, 8, 3'b001});
`ifdef SEQ_MAG_COMPARE_SIGNED_EN
        vt.push_back('{8'h80, 8'h7F, 1'b1, 1, 8, 3'b001});
        vt.push_back('{8'h7F, 8'h80, 1'b1, 1, 8, 3'b100});
        vt.push_back('{8'hFE, 8'hFF, 1'b1, 8, 8, 3'b001});
`endif
        foreach (vt[i]) begin
            launch(vt[i].va, vt[i].vb, vt[i].vs);
            chk($sformatf("v%0d_busy", i), busy_e, 1);
            watch(11);
            check_run($sformatf("v%0d", i), vt[i].le, vt[i].lf, vt[i].fl);
        end

        // Start during SCAN must be ignored
        launch(8'd3, 8'd5, 1'b0);
        watch(2);
        a     = 8'd9;
        b     = 8'd1;
        start = 1'b1;
        watch(1);
        start = 1'b0;
        watch(9);
        check_run("ign", 6, 8, 3'b001);

        // Reset at edge 4 of a full scan aborts without a done pulse
        launch(8'hA5, 8'hA5, 1'b0);
        watch(3);
        rst_n = 1'b0;
        watch(1);
        chk("mid_rst_busy_e",  busy_e, 0);
        chk("mid_rst_flags_e", {gt_e, eq_e, lt_e}, 3'b000);
        chk("mid_rst_busy_f",  busy_f, 0);
        chk("mid_rst_flags_f", {gt_f, eq_f, lt_f}, 3'b000);
        rst_n = 1'b1;
        watch(10);
        chk("mid_rst_ndone_e", nd_e, 0);
        chk("mid_rst_ndone_f", nd_f, 0);

        // Back-to-back: second start issued in the DONE cycle
        launch(8'd1, 8'd0, 1'b0);
        watch(8);
        check_run("b2b1", 8, 8, 3'b100);
        a     = 8'd0;
        b     = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_busy_e", busy_e, 1);
        chk("b2b_busy_f", busy_f, 1);
        chk("b2b_done_e", done_e, 0);
        clear_cnt();
        watch(10);
        check_run("b2b2", 8, 8, 3'b001);

        // WIDTH=2 exhaustive unsigned sweep
        for (int ia = 0; ia < 4; ia++) begin
            for (int ib = 0; ib < 4; ib++) begin
                a2     = 2'(ia);
                b2     = 2'(ib);
                start2 = 1'b1;
                tick();
                start2 = 1'b0;
                seen   = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    tick();
                    if (done_w === 1'b1) begin
                        seen = 1'b1;
                        break;
                    end
                end
                chk($sformatf("w2_done_%0d_%0d", ia, ib), seen, 1);
                chk($sformatf("w2_flags_%0d_%0d", ia, ib), {gt_w, eq_w, lt_w},
                    {ia > ib, ia == ib, ia < ib});
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
